// File: rtl/dec_entry_if.sv
// Key-strobe inputs and entry/result outputs of the decimal-entry block.
// The master side is the keypad/consumer; the slave side is dec_entry itself.
interface dec_entry_if;
    logic       digit_stb;
    logic [3:0] digit;
    logic       neg_stb;
    logic       bksp_stb;
    logic       enter_stb;
    logic       result_ack;
    logic [7:0] value;
    logic [1:0] ndigits;
    logic [7:0] result;
    logic       result_valid;
    logic       err;

    modport master (
        output digit_stb, digit, neg_stb, bksp_stb, enter_stb, result_ack,
        input  value, ndigits, result, result_valid, err
    );

    modport slave (
        input  digit_stb, digit, neg_stb, bksp_stb, enter_stb, result_ack,
        output value, ndigits, result, result_valid, err
    );
endinterface

// File: rtl/dec_entry.sv
// Decimal keypad entry of a signed 8-bit value with commit handshake.
// Optional inactivity clear of a partial entry: define DEC_ENTRY_TIMEOUT_EN.
module dec_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic        clk,
    input  logic        reset,
    dec_entry_if.slave  bus
);

    logic [7:0]  mag, mag_n;
    logic        neg, neg_n;
    logic [1:0]  ndigits, nd_n;
    logic [7:0]  result, res_n;
    logic        result_valid, valid_n;
    logic        err, err_n;
    logic [7:0]  value;
    logic [10:0] cand;
    logic [10:0] limit;
    logic        any_stb;
    logic        timeout_hit;

    assign value   = neg ? (8'd0 - mag) : mag;
    assign cand    = 11'(mag) * 11'd10 + 11'(bus.digit);
    assign limit   = neg ? 11'd128 : 11'd127;
    assign any_stb = bus.digit_stb | bus.neg_stb | bus.bksp_stb | bus.enter_stb;

`ifdef DEC_ENTRY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;

    // Counter rests at zero while nothing is entered, and saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset || any_stb || (ndigits == 2'd0 && !neg))
            idle_cnt <= '0;
        else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES))
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        mag_n   = mag;
        neg_n   = neg;
        nd_n    = ndigits;
        res_n   = result;
        valid_n = result_valid;
        err_n   = 1'b0;

        if (result_valid && bus.result_ack)
            valid_n = 1'b0;

        // Only the highest-priority strobe acts: enter > bksp > neg > digit.
        if (bus.enter_stb) begin
            if (ndigits == 2'd0 || (result_valid && !bus.result_ack)) begin
                err_n = 1'b1;
            end else begin
                res_n   = value;
                valid_n = 1'b1;
                mag_n   = 8'd0;
                neg_n   = 1'b0;
                nd_n    = 2'd0;
            end
        end else if (bus.bksp_stb) begin
            if (ndigits == 2'd0) begin
                neg_n = 1'b0;
            end else begin
                mag_n = mag / 8'd10;
                nd_n  = ndigits - 2'd1;
            end
        end else if (bus.neg_stb) begin
            if (neg && mag == 8'd128)
                err_n = 1'b1;
            else
                neg_n = ~neg;
        end else if (bus.digit_stb) begin
            if (bus.digit <= 4'd9 && ndigits < 2'd3 && cand <= limit) begin
                mag_n = cand[7:0];
                // A digit after a lone leading zero replaces it.
                if (!(ndigits == 2'd1 && mag == 8'd0))
                    nd_n = ndigits + 2'd1;
            end else begin
                err_n = 1'b1;
            end
        end else if (timeout_hit && (ndigits != 2'd0 || neg)) begin
            mag_n = 8'd0;
            neg_n = 1'b0;
            nd_n  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mag          <= 8'd0;
            neg          <= 1'b0;
            ndigits      <= 2'd0;
            result       <= 8'd0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            mag          <= mag_n;
            neg          <= neg_n;
            ndigits      <= nd_n;
            result       <= res_n;
            result_valid <= valid_n;
            err          <= err_n;
        end
    end

    assign bus.value        = value;
    assign bus.ndigits      = ndigits;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.err          = err;

endmodule

// File: tb/tb_dec_entry.sv
// Directed-vector bench for dec_entry: table of single-cycle strobes plus reset/timeout sequences.
module tb_dec_entry;

    logic clk = 1'b0;
    logic reset;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    dec_entry_if bus ();

    dec_entry #(.TIMEOUT_CYCLES(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       dstb;
        logic [3:0] digit;
        logic       nstb;
        logic       bstb;
        logic       estb;
        logic       ack;
        logic [7:0] ev;
        logic [1:0] en;
        logic [7:0] er;
        logic       evalid;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic ds, logic [3:0] d, logic ns, logic bs,
                                logic es, logic ak, logic [7:0] ev, logic [1:0] en,
                                logic [7:0] er, logic evl, logic ee);
        vec_t v;
        v.name = n; v.dstb = ds; v.digit = d; v.nstb = ns; v.bstb = bs; v.estb = es;
        v.ack = ak; v.ev = ev; v.en = en; v.er = er; v.evalid = evl; v.eerr = ee;
        return v;
    endfunction

    // Drive one cycle of inputs across a rising edge, then release strobes 1ns after it.
    task automatic applyStimulus(input logic ds, input logic [3:0] d, input logic ns,
                                 input logic bs, input logic es, input logic ak);
        bus.digit_stb  = ds;
        bus.digit      = d;
        bus.neg_stb    = ns;
        bus.bksp_stb   = bs;
        bus.enter_stb  = es;
        bus.result_ack = ak;
        @(posedge clk);
        #1;
        bus.digit_stb  = 1'b0;
        bus.neg_stb    = 1'b0;
        bus.bksp_stb   = 1'b0;
        bus.enter_stb  = 1'b0;
        bus.result_ack = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] ev, input logic [1:0] en,
                               input logic [7:0] er, input logic evl, input logic ee);
        check_cnt++;
        if (bus.value === ev && bus.ndigits === en && bus.result === er &&
            bus.result_valid === evl && bus.err === ee) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got value=%0d nd=%0d result=%0d valid=%b err=%b, expected value=%0d nd=%0d result=%0d valid=%b err=%b",
                     name, $signed(bus.value), bus.ndigits, $signed(bus.result), bus.result_valid,
                     bus.err, $signed(ev), en, $signed(er), evl, ee);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //                name         ds d     ns bs es ak  value  nd  result vld err
        vecs.push_back(mk("d1",        1, 4'd1, 0, 0, 0, 0, 8'h01, 1, 8'h00, 0, 0));
        vecs.push_back(mk("d2",        1, 4'd2, 0, 0, 0, 0, 8'h0C, 2, 8'h00, 0, 0));
        vecs.push_back(mk("d7",        1, 4'd7, 0, 0, 0, 0, 8'h7F, 3, 8'h00, 0, 0));
        vecs.push_back(mk("ent127",    0, 4'd0, 0, 0, 1, 0, 8'h00, 0, 8'h7F, 1, 0));
        vecs.push_back(mk("ack127",    0, 4'd0, 0, 0, 0, 1, 8'h00, 0, 8'h7F, 0, 0));
        vecs.push_back(mk("neg0",      0, 4'd0, 1, 0, 0, 0, 8'h00, 0, 8'h7F, 0, 0));
        vecs.push_back(mk("nd1",       1, 4'd1, 0, 0, 0, 0, 8'hFF, 1, 8'h7F, 0, 0));
        vecs.push_back(mk("nd2",       1, 4'd2, 0, 0, 0, 0, 8'hF4, 2, 8'h7F, 0, 0));
        vecs.push_back(mk("nd8",       1, 4'd8, 0, 0, 0, 0, 8'h80, 3, 8'h7F, 0, 0));
        vecs.push_back(mk("neg128",    0, 4'd0, 1, 0, 0, 0, 8'h80, 3, 8'h7F, 0, 1));
        vecs.push_back(mk("d4th",      1, 4'd8, 0, 0, 0, 0, 8'h80, 3, 8'h7F, 0, 1));
        vecs.push_back(mk("bk1",       0, 4'd0, 0, 1, 0, 0, 8'hF4, 2, 8'h7F, 0, 0));
        vecs.push_back(mk("bk2",       0, 4'd0, 0, 1, 0, 0, 8'hFF, 1, 8'h7F, 0, 0));
        vecs.push_back(mk("bk3",       0, 4'd0, 0, 1, 0, 0, 8'h00, 0, 8'h7F, 0, 0));
        vecs.push_back(mk("bkclrneg",  0, 4'd0, 0, 1, 0, 0, 8'h00, 0, 8'h7F, 0, 0));
        vecs.push_back(mk("p1",        1, 4'd1, 0, 0, 0, 0, 8'h01, 1, 8'h7F, 0, 0));
        vecs.push_back(mk("p2",        1, 4'd2, 0, 0, 0, 0, 8'h0C, 2, 8'h7F, 0, 0));
        vecs.push_back(mk("p128rej",   1, 4'd8, 0, 0, 0, 0, 8'h0C, 2, 8'h7F, 0, 1));
        vecs.push_back(mk("pbk",       0, 4'd0, 0, 1, 0, 0, 8'h01, 1, 8'h7F, 0, 0));
        vecs.push_back(mk("p0a",       1, 4'd0, 0, 0, 0, 0, 8'h0A, 2, 8'h7F, 0, 0));
        vecs.push_back(mk("p0b",       1, 4'd0, 0, 0, 0, 0, 8'h64, 3, 8'h7F, 0, 0));
        vecs.push_back(mk("ent100",    0, 4'd0, 0, 0, 1, 0, 8'h00, 0, 8'h64, 1, 0));
        vecs.push_back(mk("ack100",    0, 4'd0, 0, 0, 0, 1, 8'h00, 0, 8'h64, 0, 0));
        vecs.push_back(mk("lz0",       1, 4'd0, 0, 0, 0, 0, 8'h00, 1, 8'h64, 0, 0));
        vecs.push_back(mk("lz5",       1, 4'd5, 0, 0, 0, 0, 8'h05, 1, 8'h64, 0, 0));
        vecs.push_back(mk("lzbk",      0, 4'd0, 0, 1, 0, 0, 8'h00, 0, 8'h64, 0, 0));
        vecs.push_back(mk("ent_empty", 0, 4'd0, 0, 0, 1, 0, 8'h00, 0, 8'h64, 0, 1));
        vecs.push_back(mk("m5neg",     0, 4'd0, 1, 0, 0, 0, 8'h00, 0, 8'h64, 0, 0));
        vecs.push_back(mk("m5d",       1, 4'd5, 0, 0, 0, 0, 8'hFB, 1, 8'h64, 0, 0));
        vecs.push_back(mk("ent_m5",    0, 4'd0, 0, 0, 1, 0, 8'h00, 0, 8'hFB, 1, 0));
        vecs.push_back(mk("m3neg",     0, 4'd0, 1, 0, 0, 0, 8'h00, 0, 8'hFB, 1, 0));
        vecs.push_back(mk("m3d",       1, 4'd3, 0, 0, 0, 0, 8'hFD, 1, 8'hFB, 1, 0));
        vecs.push_back(mk("ent_pend",  0, 4'd0, 0, 0, 1, 0, 8'hFD, 1, 8'hFB, 1, 1));
        vecs.push_back(mk("ent_ack",   0, 4'd0, 0, 0, 1, 1, 8'h00, 0, 8'hFD, 1, 0));
        vecs.push_back(mk("d4",        1, 4'd4, 0, 0, 0, 0, 8'h04, 1, 8'hFD, 1, 0));
        vecs.push_back(mk("dig_ent",   1, 4'd7, 0, 0, 1, 1, 8'h00, 0, 8'h04, 1, 0));
        vecs.push_back(mk("ack4",      0, 4'd0, 0, 0, 0, 1, 8'h00, 0, 8'h04, 0, 0));
        vecs.push_back(mk("ack_idle",  0, 4'd0, 0, 0, 0, 1, 8'h00, 0, 8'h04, 0, 0));
        vecs.push_back(mk("dig12",     1, 4'd12,0, 0, 0, 0, 8'h00, 0, 8'h04, 0, 1));
        vecs.push_back(mk("c3",        1, 4'd3, 0, 0, 0, 0, 8'h03, 1, 8'h04, 0, 0));
        vecs.push_back(mk("neg_dig",   1, 4'd5, 1, 0, 0, 0, 8'hFD, 1, 8'h04, 0, 0));
        vecs.push_back(mk("bk_neg",    0, 4'd0, 1, 1, 0, 0, 8'h00, 0, 8'h04, 0, 0));
        vecs.push_back(mk("c2",        1, 4'd2, 0, 0, 0, 0, 8'hFE, 1, 8'h04, 0, 0));
        vecs.push_back(mk("ent_m2",    0, 4'd0, 0, 0, 1, 0, 8'h00, 0, 8'hFE, 1, 0));
        vecs.push_back(mk("d6",        1, 4'd6, 0, 0, 0, 0, 8'h06, 1, 8'hFE, 1, 0));

        bus.digit_stb = 0; bus.digit = 0; bus.neg_stb = 0;
        bus.bksp_stb = 0; bus.enter_stb = 0; bus.result_ack = 0;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset", 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dstb, vecs[i].digit, vecs[i].nstb,
                          vecs[i].bstb, vecs[i].estb, vecs[i].ack);
            checkOutput(vecs[i].name, vecs[i].ev, vecs[i].en, vecs[i].er,
                        vecs[i].evalid, vecs[i].eerr);
        end

        // Reset mid-entry with a result pending; strobes during reset are ignored.
        reset = 1'b1;
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_pending", 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_hold", 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst", 8'h09, 2'd1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_bk", 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);

`ifdef DEC_ENTRY_TIMEOUT_EN
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        checkOutput("to_hold", 8'h04, 2'd1, 8'h00, 1'b0, 1'b0);
        idle(1);
        checkOutput("to_clear", 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(18);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        checkOutput("to_restart", 8'hFC, 2'd1, 8'h00, 1'b0, 1'b0);
        idle(1);
        checkOutput("to_clear2", 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
`else
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(40);
        checkOutput("no_timeout", 8'h04, 2'd1, 8'h00, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
